// File: rtl/apb_pkg.sv
// Shared types for the APB requester: FSM states, command/response records
// at the default 32-bit geometry, and the watchdog counter sizing helper.
package apb_pkg;

    localparam int APB_AW = 32;
    localparam int APB_DW = 32;
    localparam int APB_SW = APB_DW / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_mst_state_e;

    typedef struct packed {
        logic [APB_AW-1:0] addr;
        logic              write;
        logic [APB_DW-1:0] wdata;
        logic [APB_SW-1:0] strb;
    } apb_cmd_t;

    typedef struct packed {
        logic [APB_DW-1:0] rdata;
        logic              slverr;
        logic              timeout;
    } apb_rsp_t;

    // A disabled watchdog still gets a 1-bit counter so the port list stays legal.
    function automatic int wd_cnt_w(input int limit);
        return (limit == 0) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/apb_mst_watchdog.sv
// Wait-state counter for the ACCESS phase; flags the cycle on which the
// count reaches TIMEOUT_CYCLES. Saturates instead of wrapping.
module apb_mst_watchdog
    import apb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic inc_i,
    output logic expired_o
);

    localparam int             CW    = wd_cnt_w(TIMEOUT_CYCLES);
    localparam bit             EN    = (TIMEOUT_CYCLES != 0);
    localparam logic [CW-1:0]  LIMIT = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0]  LAST  = (TIMEOUT_CYCLES == 0) ? '0 : CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)                         cnt_d = '0;
        else if (inc_i && cnt_q != LIMIT)  cnt_d = cnt_q + 1'b1;
    end

    // Decoded from the current count so the flag does not depend on clr_i.
    assign expired_o = EN && inc_i && (cnt_q == LAST);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

endmodule

// File: rtl/apb_master.sv
// APB3/APB4 requester: one outstanding transfer from a valid/ready command
// stream to a single slave, with a held response and a PREADY watchdog.
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH     = APB_AW,
    parameter int DATA_WIDTH     = APB_DW,
    parameter int STRB_WIDTH     = DATA_WIDTH / 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic                  cmd_write,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic [STRB_WIDTH-1:0] cmd_strb,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_slverr,
    output logic                  rsp_timeout,
    output logic                  PSELx,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    output logic [STRB_WIDTH-1:0] PSTRB,
    input  logic                  PREADY,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PSLVERR
);

    apb_mst_state_e state_q, state_d;
    logic run_q;
    logic psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic [STRB_WIDTH-1:0] pstrb_q, pstrb_d;
    logic rsp_valid_q, rsp_valid_d, rsp_slverr_q, rsp_slverr_d, rsp_timeout_q, rsp_timeout_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic accept, drop_apb, wd_inc, wd_expired;

    // run_q keeps cmd_ready low while reset is held and for the release edge.
    assign cmd_ready = (state_q == IDLE && run_q) || (state_q == RESP && rsp_ready);
    assign accept    = cmd_valid && cmd_ready;
    assign wd_inc    = (state_q == ACCESS) && !PREADY;

    apb_mst_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wd (
        .clk_i    (PCLK),
        .rst_ni   (PRESETn),
        .clr_i    (accept),
        .inc_i    (wd_inc),
        .expired_o(wd_expired)
    );

    always_comb begin
        state_d       = state_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        pstrb_d       = pstrb_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_slverr_d  = rsp_slverr_q;
        rsp_timeout_d = rsp_timeout_q;
        drop_apb      = 1'b0;
        case (state_q)
            IDLE: ;
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
            end
            ACCESS: begin
                if (PREADY) begin
                    state_d       = RESP;
                    drop_apb      = 1'b1;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = pwrite_q ? '0 : PRDATA;
                    rsp_slverr_d  = PSLVERR;
                    rsp_timeout_d = 1'b0;
                end else if (wd_expired) begin
                    state_d       = RESP;
                    drop_apb      = 1'b1;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = '0;
                    rsp_slverr_d  = 1'b1;
                    rsp_timeout_d = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d       = IDLE;
                    rsp_valid_d   = 1'b0;
                    rsp_rdata_d   = '0;
                    rsp_slverr_d  = 1'b0;
                    rsp_timeout_d = 1'b0;
                end
            end
            default: begin
                state_d       = IDLE;
                drop_apb      = 1'b1;
                rsp_valid_d   = 1'b0;
                rsp_rdata_d   = '0;
                rsp_slverr_d  = 1'b0;
                rsp_timeout_d = 1'b0;
            end
        endcase
        // Accept only happens from IDLE or a consumed RESP; both go straight to SETUP.
        if (accept) begin
            state_d   = SETUP;
            psel_d    = 1'b1;
            penable_d = 1'b0;
            pwrite_d  = cmd_write;
            paddr_d   = cmd_addr;
            pwdata_d  = cmd_write ? cmd_wdata : '0;
            pstrb_d   = cmd_write ? cmd_strb : '0;
        end else if (drop_apb) begin
            psel_d    = 1'b0;
            penable_d = 1'b0;
            pwrite_d  = 1'b0;
            paddr_d   = '0;
            pwdata_d  = '0;
            pstrb_d   = '0;
        end
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state_q       <= IDLE;
            run_q         <= 1'b0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            pstrb_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_slverr_q  <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            run_q         <= 1'b1;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            pstrb_q       <= pstrb_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_slverr_q  <= rsp_slverr_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign PSELx       = psel_q;
    assign PENABLE     = penable_q;
    assign PWRITE      = pwrite_q;
    assign PADDR       = paddr_q;
    assign PWDATA      = pwdata_q;
    assign PSTRB       = pstrb_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_slverr  = rsp_slverr_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: a behavioural APB slave driven from a per-transfer
// plan, and a transaction-level model of latency and response contents.
module tb_apb_master;
    import apb_pkg::*;

    localparam int TO = 16;

    logic        PCLK = 1'b0;
    logic        PRESETn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_addr = '0;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_strb = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_slverr, rsp_timeout;
    logic        PSELx, PENABLE, PWRITE;
    logic [31:0] PADDR, PWDATA;
    logic [3:0]  PSTRB;
    logic        PREADY = 1'b0;
    logic [31:0] PRDATA = '0;
    logic        PSLVERR = 1'b0;

    always #5 PCLK = ~PCLK;

    apb_master #(.ADDR_WIDTH(APB_AW), .DATA_WIDTH(APB_DW), .STRB_WIDTH(APB_SW),
                 .TIMEOUT_CYCLES(TO)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_write(cmd_write), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_slverr(rsp_slverr), .rsp_timeout(rsp_timeout),
        .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PSTRB(PSTRB), .PREADY(PREADY), .PRDATA(PRDATA),
        .PSLVERR(PSLVERR)
    );

    // One transfer: the command plus how the slave will answer it.
    typedef struct {
        apb_cmd_t    cmd;
        int          wt;
        logic [31:0] rdata;
        logic        err;
    } txn_t;

    int   n_chk = 0;
    int   n_err = 0;
    txn_t cq[$];
    txn_t cur;
    bit   have = 0;
    bit   mon_en = 0;
    int   acc_n = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_to(input txn_t t);
        return (TO != 0) && (t.wt >= TO);
    endfunction

    function automatic apb_rsp_t model(input txn_t t);
        apb_rsp_t r;
        if (is_to(t)) begin
            r.rdata = '0; r.slverr = 1'b1; r.timeout = 1'b1;
        end else begin
            r.rdata = t.cmd.write ? 32'h0 : t.rdata; r.slverr = t.err; r.timeout = 1'b0;
        end
        return r;
    endfunction

    function automatic int pen_of(input txn_t t);
        return is_to(t) ? TO : t.wt + 1;
    endfunction

    function automatic txn_t mk(input logic [31:0] a, input logic w, input logic [31:0] d,
                                input logic [3:0] s, input int wt, input logic [31:0] rd,
                                input logic e);
        txn_t t;
        t.cmd.addr = a; t.cmd.write = w; t.cmd.wdata = d; t.cmd.strb = s;
        t.wt = wt; t.rdata = rd; t.err = e;
        return t;
    endfunction

    function automatic txn_t rand_txn();
        int r;
        r = int'($urandom_range(0, 9));
        return mk($urandom, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
                  (r < 6) ? int'($urandom_range(0, 3)) :
                  (r < 8) ? int'($urandom_range(TO - 1, TO)) : int'($urandom_range(TO + 1, TO + 6)),
                  $urandom, 1'($urandom_range(0, 3) == 0));
    endfunction

    task automatic chk_apb(input string p);
        chk({p, "_paddr"}, PADDR, cur.cmd.addr);
        chk({p, "_pwrite"}, PWRITE, cur.cmd.write);
        chk({p, "_pwdata"}, PWDATA, cur.cmd.write ? cur.cmd.wdata : 32'h0);
        chk({p, "_pstrb"}, PSTRB, cur.cmd.write ? cur.cmd.strb : 4'h0);
    endtask

    // Slave: answers each SETUP from the plan queue, with noise on ignored inputs.
    always @(negedge PCLK) begin
        if (!PRESETn) begin
            have = 0; acc_n = 0; PREADY = 1'b0;
        end else if (mon_en) begin
            if (PSELx && !PENABLE) begin
                chk("setup_planned", cq.size() > 0, 1);
                if (cq.size() > 0) begin
                    cur = cq.pop_front(); have = 1;
                    chk_apb("setup");
                end
                acc_n = 0;
                PREADY = 1'($urandom_range(0, 1)); PRDATA = $urandom; PSLVERR = 1'($urandom_range(0, 1));
            end else if (PSELx && PENABLE) begin
                chk_apb("access");
                acc_n++;
                if (acc_n > cur.wt) begin
                    PREADY = 1'b1; PRDATA = cur.rdata; PSLVERR = cur.err;
                end else begin
                    PREADY = 1'b0; PRDATA = $urandom; PSLVERR = 1'($urandom_range(0, 1));
                end
            end else begin
                if (have) begin
                    chk("penable_cycles", acc_n, pen_of(cur));
                    have = 0;
                end
                chk("apb_idle_ctl", {PENABLE, PWRITE, PSTRB}, 0);
                chk("apb_idle_addr", PADDR, 0);
                chk("apb_idle_wdata", PWDATA, 0);
                PREADY = 1'($urandom_range(0, 1)); PRDATA = $urandom; PSLVERR = 1'($urandom_range(0, 1));
            end
        end
    end

    task automatic drive(input txn_t t);
        cmd_addr = t.cmd.addr; cmd_write = t.cmd.write;
        cmd_wdata = t.cmd.wdata; cmd_strb = t.cmd.strb;
    endtask

    task automatic do_reset(input int n);
        PRESETn = 1'b0;
        repeat (n) begin
            @(posedge PCLK); @(negedge PCLK); #1;
            chk("rst_ctl_zero", {cmd_ready, rsp_valid, rsp_slverr, rsp_timeout,
                                 PSELx, PENABLE, PWRITE, PSTRB}, 0);
            chk("rst_paddr", PADDR, 0);
            chk("rst_pwdata", PWDATA, 0);
            chk("rst_rdata", rsp_rdata, 0);
        end
        PRESETn = 1'b1;
        #1 chk("rdy_low_at_release", cmd_ready, 0);
        @(posedge PCLK); @(negedge PCLK); #1;
        chk("rdy_after_release", cmd_ready, 1);
    endtask

    task automatic send_cmd(input txn_t t);
        int n;
        bit acc;
        @(negedge PCLK);
        drive(t); cmd_valid = 1'b1; cq.push_back(t);
        n = 0; acc = 0;
        while (!acc && n < 20) begin
            #1 acc = cmd_ready;
            n++;
            @(posedge PCLK);
            if (!acc) @(negedge PCLK);
        end
        chk("idle_accept_cycles", n, 1);
        #1;
    endtask

    // Entered just after the accept edge; leaves just after the release edge.
    task automatic get_rsp(input txn_t t, input int dly, input bit b2b, input txn_t nx);
        apb_rsp_t e;
        int lat;
        bit got;
        e = model(t); lat = 0; got = 0;
        while (!got && lat < 60) begin
            @(negedge PCLK);
            cmd_valid = 1'b0; rsp_ready = 1'b0; lat++;
            #1;
            if (lat == 1) chk("setup_after_accept", {PSELx, PENABLE}, 2'b10);
            got = rsp_valid;
        end
        chk("rsp_latency", lat, pen_of(t) + 2);
        if (!got) return;
        for (int k = 0; k <= dly; k++) begin
            chk("rsp_valid_held", rsp_valid, 1);
            chk("rsp_rdata", rsp_rdata, e.rdata);
            chk("rsp_slverr", rsp_slverr, e.slverr);
            chk("rsp_timeout", rsp_timeout, e.timeout);
            if (k < dly) begin
                chk("rdy_low_in_resp", cmd_ready, 0);
                @(negedge PCLK); #1;
            end
        end
        rsp_ready = 1'b1;
        if (b2b) begin
            drive(nx); cmd_valid = 1'b1; cq.push_back(nx);
        end
        #1 chk("rdy_on_rsp_ready", cmd_ready, 1);
        @(posedge PCLK); #1;
    endtask

    initial begin
        txn_t a, b, dummy;
        bit   bb;
        dummy = mk(0, 0, 0, 0, 0, 0, 0);
        do_reset(3);
        mon_en = 1;

        a = mk(32'h0000_0010, 1, 32'hDEAD_BEEF, 4'hF, 0, 32'h5A5A_A5A5, 0);
        send_cmd(a); get_rsp(a, 0, 0, dummy);
        a = mk(32'h0000_0004, 0, 32'hFFFF_FFFF, 4'hF, 2, 32'h1234_5678, 0);
        send_cmd(a); get_rsp(a, 1, 0, dummy);
        a = mk(32'h0000_0008, 0, 32'h0, 4'h0, 1, 32'hCAFE_0001, 1);
        send_cmd(a); get_rsp(a, 0, 0, dummy);
        a = mk(32'h0000_0020, 0, 32'h0, 4'h0, 1000, 32'hBAD0_BAD0, 0);
        send_cmd(a); get_rsp(a, 2, 0, dummy);
        a = mk(32'h0000_0024, 0, 32'h0, 4'h0, TO - 1, 32'h0BAD_F00D, 0);
        send_cmd(a); get_rsp(a, 0, 0, dummy);

        a = mk(32'h0000_0100, 1, 32'h1111_2222, 4'h3, 0, 32'h7777_7777, 0);
        b = mk(32'h0000_0104, 1, 32'h3333_4444, 4'hC, 1, 32'h8888_8888, 0);
        send_cmd(a); get_rsp(a, 4, 1, b); get_rsp(b, 0, 0, dummy);

        a = mk(32'h0000_0040, 0, 32'h0, 4'h0, 1000, 32'h0, 0);
        send_cmd(a);
        @(negedge PCLK); cmd_valid = 1'b0;
        @(negedge PCLK); @(negedge PCLK); #1;
        chk("pre_reset_access", {PSELx, PENABLE}, 2'b11);
        do_reset(2);
        a = mk(32'h0000_0044, 0, 32'h0, 4'h0, 1, 32'h600D_600D, 0);
        send_cmd(a); get_rsp(a, 0, 0, dummy);

        a = rand_txn();
        send_cmd(a);
        for (int i = 0; i < 40; i++) begin
            b = rand_txn();
            bb = (i < 39) && ($urandom_range(0, 2) == 0);
            get_rsp(a, int'($urandom_range(0, 3)), bb, b);
            if (i < 39 && !bb) send_cmd(b);
            a = b;
        end

        repeat (3) @(negedge PCLK);
        chk("plan_drained", cq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete (checks %0d, errors %0d)", n_chk, n_err);
        $fatal(1);
    end

endmodule
